// File: rtl/multicycle_decoder.sv
// rtl/multicycle_decoder.sv - multicycle control FSM and ALU decoder for the ARM-subset CPU
module multicycle_decoder (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    output logic [1:0] FlagW,
    output logic       PCS,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc
);

    typedef enum logic [3:0] {
        st_fetch,
        st_decode,
        st_memadr,
        st_memrd,
        st_memwb,
        st_memwr,
        st_execr,
        st_execi,
        st_aluwb,
        st_branch,
        st_unknown
    } state_t;

    state_t state;
    logic   aluop;
    logic   branch;
    logic   is_cmp;

    // Step the instruction through its phases; reset aborts to FETCH at once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= st_fetch;
        end else begin
            case (state)
                st_fetch:  state <= st_decode;
                st_decode: begin
                    case (Op)
                        2'b00:   state <= Funct[5] ? st_execi : st_execr;
                        2'b01:   state <= st_memadr;
                        2'b10:   state <= st_branch;
                        default: state <= st_unknown;
                    endcase
                end
                st_memadr: state <= Funct[0] ? st_memrd : st_memwr;
                st_memrd:  state <= st_memwb;
                st_execr,
                st_execi:  state <= st_aluwb;
                default:   state <= st_fetch;
            endcase
        end
    end

    assign is_cmp = (Funct[4:1] == 4'b1010);

    // Per-state datapath selects and write requests; unlisted outputs stay 0
    always_comb begin
        IRWrite   = 1'b0;
        NextPC    = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        RegW      = 1'b0;
        MemW      = 1'b0;
        aluop     = 1'b0;
        branch    = 1'b0;
        case (state)
            st_fetch: begin
                IRWrite   = 1'b1;
                NextPC    = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            st_decode: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            st_memadr: ALUSrcB = 2'b01;
            st_memrd:  AdrSrc  = 1'b1;
            st_memwb: begin
                ResultSrc = 2'b01;
                RegW      = 1'b1;
            end
            st_memwr: begin
                AdrSrc = 1'b1;
                MemW   = 1'b1;
            end
            st_execr: aluop = 1'b1;
            st_execi: begin
                ALUSrcB = 2'b01;
                aluop   = 1'b1;
            end
            // CMP only sets flags, so its writeback phase requests nothing
            st_aluwb: RegW = !is_cmp;
            st_branch: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                branch    = 1'b1;
            end
            default: ;
        endcase
    end

    // ALU operation and flag-write requests, only live during execute
    always_comb begin
        ALUControl = 2'b00;
        FlagW      = 2'b00;
        if (aluop) begin
            case (Funct[4:1])
                4'b0100: ALUControl = 2'b00;
                4'b0010: ALUControl = 2'b01;
                4'b0000: ALUControl = 2'b10;
                4'b1100: ALUControl = 2'b11;
                4'b1010: ALUControl = 2'b01;
                default: ALUControl = 2'b00;
            endcase
            // C,V only make sense for the arithmetic operations
            FlagW[1] = Funct[0];
            FlagW[0] = Funct[0] & ~ALUControl[1];
        end
    end

    assign PCS    = branch | (RegW & (Rd == 4'b1111));
    assign ImmSrc = Op;
    assign RegSrc = {(Op == 2'b01), (Op == 2'b10)};

endmodule

// File: tb/tb_multicycle_decoder.sv
// tb/tb_multicycle_decoder.sv - self-checking bench for multicycle_decoder
module tb_multicycle_decoder;

    logic       clk;
    logic       reset;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [1:0] flagw;
    logic       pcs, nextpc, regw, memw, irwrite, adrsrc, alusrca;
    logic [1:0] resultsrc, alusrcb, alucontrol, immsrc, regsrc;
    logic [18:0] obs;

    int n_checks = 0;
    int n_fail   = 0;

    multicycle_decoder dut (
        .clk(clk), .reset(reset), .Op(op), .Funct(funct), .Rd(rd),
        .FlagW(flagw), .PCS(pcs), .NextPC(nextpc), .RegW(regw), .MemW(memw),
        .IRWrite(irwrite), .AdrSrc(adrsrc), .ResultSrc(resultsrc),
        .ALUSrcA(alusrca), .ALUSrcB(alusrcb), .ALUControl(alucontrol),
        .ImmSrc(immsrc), .RegSrc(regsrc)
    );

    assign obs = {flagw, pcs, nextpc, regw, memw, irwrite, adrsrc, resultsrc,
                  alusrca, alusrcb, alucontrol, immsrc, regsrc};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Number of cycles an instruction occupies, by class
    function automatic int instr_len(input logic [1:0] o, input logic [5:0] f);
        if (o == 2'b01) return f[0] ? 5 : 4;
        if (o == 2'b00) return 4;
        return 3;
    endfunction

    // Expected outputs for cycle k of an instruction (k=0 is the fetch cycle)
    function automatic logic [18:0] expect_vec(input logic [1:0] o, input logic [5:0] f,
                                               input logic [3:0] r, input int k);
        logic [1:0] e_flagw, e_res, e_srcb, e_alu;
        logic e_pcs, e_next, e_regw, e_memw, e_ir, e_adr, e_srca;
        bit is_ldr, is_str, is_dp, is_b, arith, cmp;
        e_flagw = 0; e_res = 0; e_srcb = 0; e_alu = 0;
        e_pcs = 0; e_next = 0; e_regw = 0; e_memw = 0; e_ir = 0; e_adr = 0; e_srca = 0;
        is_ldr = (o == 2'b01) && f[0];
        is_str = (o == 2'b01) && !f[0];
        is_dp  = (o == 2'b00);
        is_b   = (o == 2'b10);
        cmp    = (f[4:1] == 4'b1010);
        if (k == 0) begin
            e_ir = 1; e_next = 1; e_srca = 1; e_srcb = 2; e_res = 2;
        end else if (k == 1) begin
            e_srca = 1; e_srcb = 2; e_res = 2;
        end else if (k == 2) begin
            if (is_ldr || is_str) e_srcb = 1;
            if (is_b) begin e_srcb = 1; e_res = 2; e_pcs = 1; end
            if (is_dp) begin
                e_srcb = f[5] ? 2'd1 : 2'd0;
                if      (f[4:1] == 4'b0010 || cmp) e_alu = 1;
                else if (f[4:1] == 4'b0000)        e_alu = 2;
                else if (f[4:1] == 4'b1100)        e_alu = 3;
                else                               e_alu = 0;
                arith   = (e_alu == 0) || (e_alu == 1);
                e_flagw = {f[0], f[0] && arith};
            end
        end else if (k == 3) begin
            if (is_ldr) e_adr = 1;
            if (is_str) begin e_adr = 1; e_memw = 1; end
            if (is_dp) begin e_regw = !cmp; e_pcs = !cmp && (r == 4'hF); end
        end else if (k == 4) begin
            if (is_ldr) begin e_res = 1; e_regw = 1; e_pcs = (r == 4'hF); end
        end
        return {e_flagw, e_pcs, e_next, e_regw, e_memw, e_ir, e_adr, e_res,
                e_srca, e_srcb, e_alu, o, (o == 2'b01), (o == 2'b10)};
    endfunction

    task automatic check(input string tag, input logic [18:0] o, input logic [18:0] e);
        n_checks++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    task automatic check_bit(input string tag, input logic o, input logic e);
        n_checks++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, o, e);
        end
    endtask

    // Called in the low clock phase with the FSM in FETCH; returns likewise
    task automatic run_instr(input string name, input logic [1:0] o,
                             input logic [5:0] f, input logic [3:0] r);
        op = o; funct = f; rd = r;
        for (int k = 0; k < instr_len(o, f); k++) begin
            #1;
            check($sformatf("%s op=%b funct=%b rd=%h cycle%0d", name, o, f, r, k),
                  obs, expect_vec(o, f, r, k));
            @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b0;
        op = 2'b01; funct = 6'b011001; rd = 4'h3;
        #12;
        check("reset_values", obs, expect_vec(op, funct, rd, 0));
        @(negedge clk);
        reset = 1'b1;

        run_instr("ldr",   2'b01, 6'b011001, 4'h3);
        run_instr("str",   2'b01, 6'b011000, 4'h3);
        run_instr("subs",  2'b00, 6'b000101, 4'h2);
        run_instr("orrsi", 2'b00, 6'b111001, 4'h2);
        run_instr("cmp",   2'b00, 6'b010101, 4'h0);
        run_instr("addpc", 2'b00, 6'b001000, 4'hF);
        run_instr("ldrpc", 2'b01, 6'b011001, 4'hF);
        run_instr("b",     2'b10, 6'b000000, 4'h0);
        run_instr("undef", 2'b11, 6'b111111, 4'hF);

        // Explicit spot checks of the SUBS execute cycle
        op = 2'b00; funct = 6'b000101; rd = 4'h2;
        @(negedge clk); @(negedge clk); #1;
        check_bit("subs_flagw1", flagw[1], 1'b1);
        check_bit("subs_flagw0", flagw[0], 1'b1);
        check_bit("subs_aluctl", alucontrol == 2'b01, 1'b1);
        @(negedge clk); @(negedge clk);

        // Reset pulse while a store is in its write cycle
        op = 2'b01; funct = 6'b011000; rd = 4'h1;
        @(negedge clk); @(negedge clk); @(negedge clk); #1;
        check_bit("str_memw_before_reset", memw, 1'b1);
        reset = 1'b0;
        #1;
        check_bit("reset_kills_memw", memw, 1'b0);
        check("reset_async_fetch", obs, expect_vec(op, funct, rd, 0));
        #1;
        reset = 1'b1;
        #1;
        check("after_release_fetch", obs, expect_vec(op, funct, rd, 0));
        @(negedge clk); #1;
        check("after_release_decode", obs, expect_vec(op, funct, rd, 1));
        @(negedge clk); @(negedge clk); @(negedge clk);

        // Random instructions against the reference model
        for (int i = 0; i < 80; i++) begin
            logic [1:0] ro;
            logic [5:0] rf;
            logic [3:0] rr;
            ro = 2'($urandom_range(0, 3));
            rf = 6'($urandom);
            rr = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
            run_instr($sformatf("rand%0d", i), ro, rf, rr);
        end
        #1;
        check("final_fetch", obs, expect_vec(op, funct, rd, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
